// File: rtl/mode_counter_pkg.sv
// Shared constants and types for the up/down mode counter.
package mode_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/mode_counter_step.sv
// Next-value logic: hold, increment or decrement with natural modulo-2^WIDTH wrap.
module mode_counter_step
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             enable,
  input  logic             sel,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e dir;
  assign dir = dir_e'(sel);

  // Wrap falls out of WIDTH-bit truncation in both directions.
  always_comb begin
    nxt = cur;
    if (enable) begin
      if (dir == DIR_DOWN) nxt = cur - ONE;
      else                 nxt = cur + ONE;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Registered up/down counter with enable; synchronous active-low reset.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;

  mode_counter_step #(.WIDTH(WIDTH)) u_step (
    .cur    (count),
    .enable (enable),
    .sel    (sel),
    .nxt    (count_nxt)
  );

  // Reset wins over any step request at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) count <= '0;
    else      count <= count_nxt;
  end

  assign out = count;

endmodule

// File: tb/tb_mode_counter.sv
// Directed test of mode_counter with hand-computed expected counts.
module tb_mode_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sel;
  logic [3:0] out;

  int n_chk  = 0;
  int n_pass = 0;

  mode_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .sel    (sel),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic edge_chk(input string tag, input logic r, input logic en, input logic s,
                          input logic [3:0] exp);
    @(negedge clk);
    rst    = r;
    enable = en;
    sel    = s;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; sel = 1'b0;

    edge_chk("reset_e1", 1'b0, 1'b1, 1'b0, 4'd0);
    edge_chk("reset_e2", 1'b0, 1'b1, 1'b0, 4'd0);

    // Up count through the 15 -> 0 wrap: 1..15, 0, 1
    for (int i = 0; i < 17; i++)
      edge_chk($sformatf("up_%0d", i), 1'b1, 1'b1, 1'b0, 4'((i + 1) % 16));

    edge_chk("up_to_2", 1'b1, 1'b1, 1'b0, 4'd2);
    edge_chk("dn_1",  1'b1, 1'b1, 1'b1, 4'd1);
    edge_chk("dn_0",  1'b1, 1'b1, 1'b1, 4'd0);
    edge_chk("dn_15", 1'b1, 1'b1, 1'b1, 4'd15);
    edge_chk("dn_14", 1'b1, 1'b1, 1'b1, 4'd14);

    edge_chk("up_15", 1'b1, 1'b1, 1'b0, 4'd15);
    edge_chk("up_0",  1'b1, 1'b1, 1'b0, 4'd0);
    edge_chk("up_1",  1'b1, 1'b1, 1'b0, 4'd1);
    edge_chk("up_2",  1'b1, 1'b1, 1'b0, 4'd2);
    edge_chk("up_3",  1'b1, 1'b1, 1'b0, 4'd3);
    edge_chk("up_4",  1'b1, 1'b1, 1'b0, 4'd4);
    edge_chk("up_5",  1'b1, 1'b1, 1'b0, 4'd5);

    edge_chk("hold_a", 1'b1, 1'b0, 1'b1, 4'd5);
    edge_chk("hold_b", 1'b1, 1'b0, 1'b0, 4'd5);
    edge_chk("hold_c", 1'b1, 1'b0, 1'b1, 4'd5);
    edge_chk("resume_6", 1'b1, 1'b1, 1'b0, 4'd6);

    edge_chk("up_7", 1'b1, 1'b1, 1'b0, 4'd7);
    edge_chk("up_8", 1'b1, 1'b1, 1'b0, 4'd8);
    edge_chk("up_9", 1'b1, 1'b1, 1'b0, 4'd9);
    edge_chk("dirchg_8", 1'b1, 1'b1, 1'b1, 4'd8);

    edge_chk("up_9b",  1'b1, 1'b1, 1'b0, 4'd9);
    edge_chk("up_10",  1'b1, 1'b1, 1'b0, 4'd10);
    edge_chk("up_11",  1'b1, 1'b1, 1'b0, 4'd11);
    edge_chk("midrst", 1'b0, 1'b1, 1'b0, 4'd0);
    edge_chk("post_rst_1", 1'b1, 1'b1, 1'b0, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
